// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: timed access sequencer for the 64x64 SRAM macro.
// Takes one read/write request at a time and walks precharge, wordline,
// write-drive or sense, then a one-cycle done. All array strobes are decoded
// from the state register so nothing on req_* can reach the array directly.
module sram_access_ctrl #(
  parameter int ROW_W  = 6,
  parameter int COL_W  = 3,
  parameter int DATA_W = 8,
  parameter int T_PRE  = 2,
  parameter int T_WL   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ROW_W+COL_W-1:0] req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   done,
  output logic [DATA_W-1:0]      rdata,
  output logic                   pre_en,
  output logic                   wl_en,
  output logic [ROW_W-1:0]       row_addr,
  output logic [COL_W-1:0]       col_sel,
  output logic                   wd_en,
  output logic [DATA_W-1:0]      wd_data,
  output logic                   sa_en,
  input  logic [DATA_W-1:0]      sa_out
);

  typedef enum logic [2:0] {IDLE, PRE, ACT, SENSE, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  req_t       req_q;
  logic       accept;

  // Ready is held low while reset is asserted, even though the state is IDLE.
  assign accept = req_valid && req_ready;

  // State and phase counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state sequencing and Moore strobe decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    pre_en    = 1'b0;
    wl_en     = 1'b0;
    wd_en     = 1'b0;
    sa_en     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (accept) begin
          state_nxt = PRE;
          cnt_nxt   = 4'(T_PRE - 1);
        end
      end
      PRE: begin
        pre_en = 1'b1;
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          cnt_nxt   = 4'(T_WL - 1);
          state_nxt = ACT;
        end
      end
      ACT: begin
        wl_en = 1'b1;
        wd_en = req_q.we;
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else             state_nxt = req_q.we ? DONE : SENSE;
      end
      SENSE: begin
        wl_en     = 1'b1;
        sa_en     = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        // Wordline already closed here, so the next precharge cannot overlap it.
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on acceptance; held stable until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n)      req_q <= '0;
    else if (accept) req_q <= '{we: req_we,
                                row: req_addr[ROW_W+COL_W-1:COL_W],
                                col: req_addr[COL_W-1:0],
                                wdata: req_wdata};
  end

  assign row_addr = req_q.row;
  assign col_sel  = req_q.col;
  assign wd_data  = req_q.wdata;

  // Sense-amp data is taken at the end of the single SENSE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)              rdata <= '0;
    else if (state == SENSE) rdata <= sa_out;
  end

  // Configuration range and strobe-exclusivity checks (simulation only).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (T_PRE >= 1 && T_PRE <= 15) else $error("T_PRE out of range 1..15");
      assert (T_WL  >= 1 && T_WL  <= 15) else $error("T_WL out of range 1..15");
      assert (!(pre_en && (wl_en || wd_en || sa_en))) else $error("precharge overlaps access strobe");
      assert (!(wd_en && sa_en)) else $error("write driver overlaps sense amp");
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl: three instances (default, fastest,
// slowest timing). Stimulus pushes the expected transaction; a negedge monitor
// pops on acceptance and checks every cycle's strobes against the timing model.
module tb_sram_access_ctrl;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       valid [N];
  logic       ready [N];
  logic       we    [N];
  logic       done  [N];
  logic       pre   [N];
  logic       wl    [N];
  logic       wd    [N];
  logic       sa    [N];
  logic [8:0] addr  [N];
  logic [7:0] wdata [N];
  logic [7:0] rdata [N];
  logic [7:0] wdd   [N];
  logic [7:0] sa_out[N];
  logic [5:0] row   [N];
  logic [2:0] col   [N];
  logic [7:0] mem   [N][512];

  typedef struct {
    logic       we;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  exp_t sb   [N][$];
  exp_t cur  [N];
  bit   busy [N];
  int   k    [N];
  int   errors = 0;
  int   checks = 0;
  logic rst_q  = 1'b0;

  function automatic int tp(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    sram_access_ctrl #(
      .T_PRE(g == 0 ? 2 : (g == 1 ? 1 : 15)),
      .T_WL (g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(valid[g]),
      .req_ready(ready[g]),
      .req_we   (we[g]),
      .req_addr (addr[g]),
      .req_wdata(wdata[g]),
      .done     (done[g]),
      .rdata    (rdata[g]),
      .pre_en   (pre[g]),
      .wl_en    (wl[g]),
      .row_addr (row[g]),
      .col_sel  (col[g]),
      .wd_en    (wd[g]),
      .wd_data  (wdd[g]),
      .sa_en    (sa[g]),
      .sa_out   (sa_out[g])
    );
    // Array model: sense amps see whatever the addressed cell holds.
    assign sa_out[g] = mem[g][{row[g], col[g]}];
  end

  // Array model write: cell takes the driver value while wd_en is high.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (wd[i] === 1'b1) mem[i][{row[i], col[i]}] <= wdd[i];
  end

  always @(posedge clk) rst_q <= rst_n;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @%0t: got %0h want %0h", nm, i, $time, act, exp);
    end
  endtask

  // Monitor: per-cycle strobe model, pops the scoreboard on acceptance.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [5:0] act_v, exp_v;
      logic       rdy_e;
      bit         was_busy;
      int         kk, t, lat;
      if (!rst_q) begin
        busy[i] = 1'b0;
        sb[i].delete();
        chk("reset_regs", i, {rdata[i], wdd[i], row[i], col[i]}, 32'd0);
      end
      was_busy = busy[i];
      rdy_e    = !busy[i] && rst_n;
      act_v    = {ready[i], pre[i], wl[i], wd[i], sa[i], done[i]};
      if (busy[i]) begin
        kk    = k[i];
        t     = tp(i);
        lat   = cur[i].lat;
        exp_v = {1'b0, kk < t, kk >= t && kk < lat, cur[i].we && kk >= t && kk < lat,
                 !cur[i].we && kk == lat - 1, kk == lat};
      end else begin
        exp_v = {rdy_e, 5'b0};
      end
      chk("strobes", i, {26'd0, act_v}, {26'd0, exp_v});
      chk("overlap", i, {pre[i] && (wl[i] || wd[i] || sa[i]), wd[i] && sa[i]}, 32'd0);
      if (busy[i]) begin
        chk("addr_hold", i, {row[i], col[i]}, cur[i].addr);
        chk("wd_data", i, wdd[i], cur[i].wdata);
        if (k[i] == cur[i].lat) begin
          if (!cur[i].we) chk("rdata", i, rdata[i], cur[i].rdata);
          busy[i] = 1'b0;
        end else begin
          k[i]++;
        end
      end
      if (!was_busy && valid[i] === 1'b1 && rdy_e) begin
        if (sb[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL accept_unexpected[%0d] @%0t: got accept want none", i, $time);
        end else begin
          cur[i]  = sb[i].pop_front();
          busy[i] = 1'b1;
          k[i]    = 0;
        end
      end
    end
  end

  // Present a request and hold it until the accepting edge.
  task automatic issue(input int i, input logic w, input logic [8:0] a, input logic [7:0] d,
                       input logic [7:0] rd, input int lat);
    exp_t e;
    int   n;
    e.we = w; e.addr = a; e.wdata = d; e.rdata = rd; e.lat = lat;
    sb[i].push_back(e);
    we[i] = w; addr[i] = a; wdata[i] = d; valid[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready[i] !== 1'b1 && n < 300);
    chk("accept_timeout", i, {31'd0, ready[i]}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Drop valid and wait for the outstanding transactions to finish.
  task automatic drain(input int i);
    int n;
    valid[i] = 1'b0;
    n = 0;
    while ((busy[i] || sb[i].size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout[%0d] @%0t: got busy want idle", i, $time);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      valid[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // defaults: write {5,3}=0xA5 then read it back
    issue(0, 1'b1, 9'd43, 8'hA5, 8'h00, 4);
    drain(0);
    issue(0, 1'b0, 9'd43, 8'h11, 8'hA5, 5);
    drain(0);

    // T_PRE=T_WL=1
    issue(1, 1'b1, 9'd170, 8'h96, 8'h00, 2);
    drain(1);
    issue(1, 1'b0, 9'd170, 8'h00, 8'h96, 3);
    drain(1);

    // T_PRE=T_WL=15
    issue(2, 1'b1, 9'd511, 8'h0F, 8'h00, 30);
    drain(2);
    issue(2, 1'b0, 9'd511, 8'hFF, 8'h0F, 31);
    drain(2);

    // back-to-back with valid held high
    issue(0, 1'b1, 9'd81, 8'h3C, 8'h00, 4);
    issue(0, 1'b0, 9'd43, 8'h00, 8'hA5, 5);
    issue(0, 1'b0, 9'd81, 8'h00, 8'h3C, 5);
    drain(0);

    // reset during the write's ACT phase, then a clean read
    issue(0, 1'b1, 9'd167, 8'h5A, 8'h00, 4);
    valid[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wl[0] !== 1'b1 && n < 20);
    chk("reach_act", 0, {31'd0, wl[0]}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue(0, 1'b0, 9'd81, 8'h00, 8'h3C, 5);
    drain(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

Access sequencer for the 64x64 SRAM macro. It accepts one read or write request at a time over a ready/valid handshake and drives the timed array-control sequence: bitline precharge, wordline assertion, write-driver enable or sense-amp enable, and data capture. It sits between the digital front end (TT user pins and registers) and the row decoder, column mux, write drivers and sense amps, and is the only block that asserts the array control strobes.

## Interface
Parameters:
- ROW_W, 6: row address width (64 wordlines).
- COL_W, 3: column-group select width (8 groups of DATA_W bits per row).
- DATA_W, 8: data word width.
- T_PRE, 2: precharge cycles; legal range 1..15.
- T_WL, 2: wordline-active cycles before sense or write completion; legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ROW_W+COL_W  {row, col}; row is the MSBs.
- req_wdata  in  DATA_W  write data.
- done  out  1  one-cycle pulse marking access completion.
- rdata  out  DATA_W  read data; valid from the done cycle until the next read's done.
- pre_en  out  1  bitline precharge enable.
- wl_en  out  1  wordline gate to the row decoder.
- row_addr  out  ROW_W  registered row to the decoder.
- col_sel  out  COL_W  registered column-group select.
- wd_en  out  1  write-driver enable (drivers are hi-Z when low).
- wd_data  out  DATA_W  registered write data to the drivers.
- sa_en  out  1  sense-amp enable.
- sa_out  in  DATA_W  sense-amp outputs, sampled on the last sa_en cycle.

## Operation
- FSM states: IDLE, PRE, ACT, SENSE, DONE. One 4-bit down-counter times PRE and ACT.
- IDLE: req_ready=1, all strobes 0. On req_valid and req_ready, register the address, we and wdata, load counter = T_PRE-1, and go to PRE.
- PRE: pre_en=1. Stay while counter≠0 (decrement). At 0, load T_WL-1 and go to ACT.
- ACT: wl_en=1. wd_en=1 if the request is a write. At counter 0, a read goes to SENSE and a write goes to DONE.
- SENSE (read only): wl_en=1, sa_en=1. rdata <= sa_out at the end of the cycle. Next state is DONE.
- DONE: done=1. All strobes 0 (wordline closed before any new precharge). Next state is IDLE.
- All outputs are registered or state-decoded Moore outputs, with no combinational path from req_* to array strobes.
- Invariants:
  - pre_en never overlaps wl_en, wd_en or sa_en.
  - wd_en and sa_en are never both 1.
  - row_addr and col_sel stay stable from PRE entry through DONE.
- req_ready=0 in every state except IDLE. A request held valid during a busy period is taken on the first IDLE cycle.
- Out-of-range T_PRE or T_WL is a configuration error. It is flagged by a simulation-only assertion with no RTL handling.

## Timing
- Cycle 0 is the first PRE cycle, i.e. the cycle after the accepting edge.
- Read: PRE cycles 0..T_PRE-1, ACT T_PRE..T_PRE+T_WL-1, SENSE T_PRE+T_WL, done at T_PRE+T_WL+1. With defaults, done is at cycle 5.
- Write: PRE, then ACT with wd_en, then done at T_PRE+T_WL. With defaults, done is at cycle 4.
- req_ready returns to 1 the cycle after done. Back-to-back throughput with defaults is one read per 7 cycles or one write per 6 cycles, counting the acceptance cycle.
- Reset (rst_n=0 sampled at an edge, in any state including mid-access):
  - Next cycle: state IDLE; pre_en, wl_en, wd_en, sa_en and done = 0; rdata, wd_data, row_addr and col_sel = 0.
  - req_ready=0 while rst_n=0, and 1 in the first cycle after release.
  - An aborted access produces no done pulse.
- A request presented in the DONE cycle is not accepted until the following IDLE cycle.

## Test plan
- Reset then idle: rst_n low for 2 cycles, then release. Required: all strobes 0, rdata=0, req_ready=1 the cycle after release, no done.
- Write then read, defaults: write addr {row 5, col 3}, data 0xA5. Required: pre_en for cycles 0–1, wl_en and wd_en for cycles 2–3 with wd_data=0xA5 and row_addr=5, done at cycle 4. Then read the same address with the sa_out model returning 0xA5. Required: sa_en only at cycle 4, done at cycle 5, rdata=0xA5.
- Parameter sweep: T_PRE=1, T_WL=1 and T_PRE=15, T_WL=15. Required: read done at cycles 3 and 31, write done at cycles 2 and 30.
- Back-to-back: req_valid held high for 3 mixed requests. Required: each accepted only in IDLE, req_ready low throughout busy states, no strobe overlap (assertion-checked every cycle).
- Reset mid-access: assert rst_n=0 during ACT of a write. Required: wd_en and wl_en drop to 0 next cycle, no done, and the next read completes normally.
